// File: rtl/adaptation.sv
// adaptation: two-stage pipeline that adapts one road's green time per cycle from its
// vehicle count against the four-road average, clamped to [TG_MIN, TG_MAX].
module adaptation #(
    parameter int TG_MIN = 5,
    parameter int TG_MAX = 60,
    parameter int SHIFT  = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] next_road,
    input  logic [7:0] N_n,
    input  logic [7:0] N_e,
    input  logic [7:0] N_s,
    input  logic [7:0] N_w,
    input  logic [7:0] TGin,
    input  logic [7:0] TGie,
    input  logic [7:0] TGis,
    input  logic [7:0] TGiw,
    output logic [7:0] TGn,
    output logic [7:0] TGe,
    output logic [7:0] TGs,
    output logic [7:0] TGw
);
    logic [9:0]        sum;
    logic [7:0]        n_sel, tgi_sel;
    logic              init;
    logic [1:0]        road_r;
    logic [7:0]        n_r, tgi_r, avg_r;
    logic              ge;
    logic [7:0]        diff, step, tg;
    logic [8:0]        up;
    logic signed [9:0] dn, v;

    assign sum = {2'b0, N_n} + {2'b0, N_e} + {2'b0, N_s} + {2'b0, N_w};

    always_comb begin
        n_sel   = next_road == 2'd0 ? N_n  : next_road == 2'd1 ? N_e  : next_road == 2'd2 ? N_s  : N_w;
        tgi_sel = next_road == 2'd0 ? TGin : next_road == 2'd1 ? TGie : next_road == 2'd2 ? TGis : TGiw;
    end

    // Adapted value is always derived from the base time, so reselecting a road is idempotent.
    always_comb begin
        ge   = n_r >= avg_r;
        diff = ge ? n_r - avg_r : avg_r - n_r;
        step = diff >> SHIFT;
        up   = {1'b0, tgi_r} + {1'b0, step};
        dn   = $signed({2'b0, tgi_r}) - $signed({2'b0, step});
        v    = ge ? $signed({1'b0, up}) : dn;
        tg   = v < $signed(10'(TG_MIN)) ? 8'(TG_MIN) : v > $signed(10'(TG_MAX)) ? 8'(TG_MAX) : v[7:0];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            road_r <= '0;
            n_r    <= '0;
            tgi_r  <= '0;
            avg_r  <= '0;
        end else begin
            road_r <= next_road;
            n_r    <= n_sel;
            tgi_r  <= tgi_sel;
            avg_r  <= sum[9:2];
        end
    end

    // First edge after reset loads the base times unclamped; adaptation starts on the next.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            init <= 1'b0;
            TGn  <= '0;
            TGe  <= '0;
            TGs  <= '0;
            TGw  <= '0;
        end else if (!init) begin
            init <= 1'b1;
            TGn  <= TGin;
            TGe  <= TGie;
            TGs  <= TGis;
            TGw  <= TGiw;
        end else begin
            TGn <= road_r == 2'd0 ? tg : TGn;
            TGe <= road_r == 2'd1 ? tg : TGe;
            TGs <= road_r == 2'd2 ? tg : TGs;
            TGw <= road_r == 2'd3 ? tg : TGw;
        end
    end
endmodule

// File: tb/tb_adaptation.sv
// tb_adaptation: directed spec examples plus randomized traffic, checked against a
// queue-based behavioural model of the adaptation rule.
module tb_adaptation;
    localparam int TG_MIN = 5;
    localparam int TG_MAX = 60;
    localparam int SHIFT  = 1;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] next_road = '0;
    logic [7:0] n_in[4];
    logic [7:0] tgi_in[4];
    logic [7:0] tg[4];

    int errors = 0;
    int checks = 0;

    typedef struct {int road; int n; int tgi; int avg;} samp_t;
    samp_t pipe[$];
    int    exp_tg[4];
    bit    m_init;

    adaptation #(.TG_MIN(TG_MIN), .TG_MAX(TG_MAX), .SHIFT(SHIFT)) dut (
        .clk(clk), .reset(reset), .next_road(next_road),
        .N_n(n_in[0]), .N_e(n_in[1]), .N_s(n_in[2]), .N_w(n_in[3]),
        .TGin(tgi_in[0]), .TGie(tgi_in[1]), .TGis(tgi_in[2]), .TGiw(tgi_in[3]),
        .TGn(tg[0]), .TGe(tg[1]), .TGs(tg[2]), .TGw(tg[3])
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, want);
        end
    endtask

    function automatic int adapt(input samp_t s);
        int d, v;
        d = s.n - s.avg;
        v = d >= 0 ? s.tgi + d / (1 << SHIFT) : s.tgi - (-d) / (1 << SHIFT);
        return v < TG_MIN ? TG_MIN : v > TG_MAX ? TG_MAX : v;
    endfunction

    task automatic check_all(input string tag);
        for (int i = 0; i < 4; i++) check($sformatf("%s_tg%0d", tag, i), 32'(tg[i]), 32'(exp_tg[i]));
    endtask

    task automatic tick();
        samp_t s;
        @(posedge clk);
        if (reset) begin
            if (!m_init) begin
                for (int i = 0; i < 4; i++) exp_tg[i] = tgi_in[i];
                m_init = 1;
            end else if (pipe.size() > 0) begin
                s = pipe.pop_front();
                exp_tg[s.road] = adapt(s);
            end
            s.road = int'(next_road);
            s.n    = n_in[next_road];
            s.tgi  = tgi_in[next_road];
            s.avg  = (n_in[0] + n_in[1] + n_in[2] + n_in[3]) / 4;
            pipe.push_back(s);
        end
        #1 check_all("tick");
    endtask

    task automatic set_in(input int road, input int a, input int b, input int c, input int d);
        @(negedge clk);
        next_road = 2'(road);
        n_in[0] = 8'(a); n_in[1] = 8'(b); n_in[2] = 8'(c); n_in[3] = 8'(d);
    endtask

    task automatic assert_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        pipe.delete();
        m_init = 0;
        for (int i = 0; i < 4; i++) exp_tg[i] = 0;
        check_all("rst");
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            n_in[i] = 8'd20;
            tgi_in[i] = 8'd10;
            exp_tg[i] = 0;
        end
        #12 check_all("por");
        @(negedge clk) reset = 1'b1;
        tick();
        check("init_tgn", 32'(tg[0]), 32'd10);
        tick();
        tick();
        check("steady_tgw", 32'(tg[3]), 32'd10);

        set_in(0, 43, 22, 20, 15); tick();
        set_in(1, 43, 22, 20, 15); tick();
        check("ex_tgn19", 32'(tg[0]), 32'd19);
        check("ex_tge_hold", 32'(tg[1]), 32'd10);
        set_in(2, 30, 34, 25, 15); tick();
        check("ex_tge9", 32'(tg[1]), 32'd9);
        check("ex_tgn_hold", 32'(tg[0]), 32'd19);
        set_in(3, 30, 34, 25, 15); tick();
        check("ex_tgs10", 32'(tg[2]), 32'd10);
        tgi_in[0] = 8'd50;
        set_in(0, 255, 0, 0, 0); tick();
        check("ex_tgw_min", 32'(tg[3]), 32'd5);
        set_in(3, 255, 255, 255, 0); tick();
        check("clamp_max", 32'(tg[0]), 32'd60);
        tick();
        check("clamp_min", 32'(tg[3]), 32'd5);

        for (int k = 0; k < 300; k++) begin
            if (k == 120 || k == 230) begin
                assert_reset();
                for (int j = 0; j < 3; j++) begin
                    @(negedge clk) next_road = next_road + 2'd1;
                    tick();
                end
                @(negedge clk) reset = 1'b1;
                tick();
                for (int i = 0; i < 4; i++) check($sformatf("rel_tg%0d", i), 32'(tg[i]), 32'(tgi_in[i]));
            end
            @(negedge clk);
            next_road = 2'($urandom_range(0, 3));
            for (int i = 0; i < 4; i++) begin
                n_in[i]   = ($urandom_range(0, 7) == 0) ? 8'(255 * $urandom_range(0, 1)) : 8'($urandom_range(0, 255));
                tgi_in[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, 70));
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
